// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the three memory requesters (fetch, data, loader),
// the single-port RAM and the arbiter that shares the RAM between them.
interface mem_port_arbiter_if;
  // Processor state: loader is only served while the core is halted
  logic        halted;

  // Instruction fetch port (read-only)
  logic        if_req;
  logic [15:0] if_addr;
  logic [15:0] if_rdata;
  logic        if_ack;

  // LD/ST data port
  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic [15:0] d_rdata;
  logic        d_ack;

  // Program loader / debug port
  logic        ld_req;
  logic        ld_we;
  logic [15:0] ld_addr;
  logic [15:0] ld_wdata;
  logic [15:0] ld_rdata;
  logic        ld_ack;

  // Single-port RAM command and read-back
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  // Arbiter status
  logic [1:0]  grant;
  logic        busy;

  // Arbiter side
  modport slave (
    input  halted,
    input  if_req, if_addr,
    output if_rdata, if_ack,
    input  d_req, d_we, d_addr, d_wdata,
    output d_rdata, d_ack,
    input  ld_req, ld_we, ld_addr, ld_wdata,
    output ld_rdata, ld_ack,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output grant, busy
  );

  // Requester / RAM side
  modport master (
    output halted,
    output if_req, if_addr,
    input  if_rdata, if_ack,
    output d_req, d_we, d_addr, d_wdata,
    input  d_rdata, d_ack,
    output ld_req, ld_we, ld_addr, ld_wdata,
    input  ld_rdata, ld_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  grant, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Three-way arbiter for a single-port RAM with one-cycle read latency.
// Each transaction runs IDLE -> ACCESS -> RESP -> IDLE; the owner's ack
// pulses in the IDLE cycle that follows RESP, and a new grant may be
// issued in that same cycle, giving a 3-cycle throughput.
// Priority is loader > data > fetch, with a starvation override that lets
// fetch outrank data after STARVE_LIMIT consecutive data grants.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic             clk,
  input  logic             rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ACCESS = 2'b01,
    S_RESP   = 2'b10
  } state_e;

  // Encodings double as the externally visible grant value
  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_IF   = 2'b01,
    OWN_D    = 2'b10,
    OWN_LD   = 2'b11
  } owner_e;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } cmd_t;

  localparam int unsigned   CNT_W   = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  state_e           state_q;
  state_e           state_d;
  owner_e           owner_q;
  owner_e           winner;
  cmd_t             sel_cmd;
  logic             lat_we_q;
  logic [CNT_W-1:0] starve_q;
  logic             ld_elig;
  logic             d_elig;
  logic             if_elig;
  logic             starved;
  logic             busy_c;

  // Pick the winner among eligible requesters; a port whose ack is high
  // this cycle is still holding its old request and must not be re-served.
  // NOTE: every signal assigned in an always_comb gets a default first so no latch is inferred.
  always_comb begin
    ld_elig = bus.ld_req & bus.halted & ~bus.ld_ack;
    d_elig  = bus.d_req & ~bus.d_ack;
    if_elig = bus.if_req & ~bus.if_ack;
    starved = bus.if_req && (starve_q == CNT_MAX);
    winner  = OWN_NONE;
    if (ld_elig) begin
      winner = OWN_LD;
    end else if (if_elig && starved) begin
      winner = OWN_IF;
    end else if (d_elig) begin
      winner = OWN_D;
    end else if (if_elig) begin
      winner = OWN_IF;
    end
  end

  // Route the winner's command to the latch inputs; fetch never writes
  always_comb begin
    sel_cmd = '0;
    case (winner)
      OWN_IF:  sel_cmd = {1'b0, bus.if_addr, 16'h0000};
      OWN_D:   sel_cmd = {bus.d_we, bus.d_addr, bus.d_wdata};
      OWN_LD:  sel_cmd = {bus.ld_we, bus.ld_addr, bus.ld_wdata};
      default: sel_cmd = '0;
    endcase
  end

  // Next-state and status decode
  always_comb begin
    state_d = state_q;
    busy_c  = (state_q != S_IDLE);
    case (state_q)
      S_IDLE:   if (winner != OWN_NONE) state_d = S_ACCESS;
      S_ACCESS: state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  assign bus.busy  = busy_c;
  assign bus.grant = owner_q;

  // State register; reset abandons any transaction in flight
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Command latch, RAM drive, read-data capture and ack generation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q       <= OWN_NONE;
      lat_we_q      <= 1'b0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= 16'h0000;
      bus.mem_wdata <= 16'h0000;
      bus.if_ack    <= 1'b0;
      bus.d_ack     <= 1'b0;
      bus.ld_ack    <= 1'b0;
      bus.if_rdata  <= 16'h0000;
      bus.d_rdata   <= 16'h0000;
      bus.ld_rdata  <= 16'h0000;
    end else begin
      bus.if_ack <= 1'b0;
      bus.d_ack  <= 1'b0;
      bus.ld_ack <= 1'b0;
      case (state_q)
        S_IDLE: begin
          owner_q <= winner;
          if (winner != OWN_NONE) begin
            // mem_addr/mem_wdata double as the command latch and hold
            // their value through RESP
            lat_we_q      <= sel_cmd.we;
            bus.mem_en    <= 1'b1;
            bus.mem_we    <= sel_cmd.we;
            bus.mem_addr  <= sel_cmd.addr;
            bus.mem_wdata <= sel_cmd.wdata;
          end
        end
        S_ACCESS: begin
          bus.mem_en <= 1'b0;
          bus.mem_we <= 1'b0;
        end
        S_RESP: begin
          owner_q <= OWN_NONE;
          case (owner_q)
            OWN_IF: begin
              bus.if_ack <= 1'b1;
              if (!lat_we_q) bus.if_rdata <= bus.mem_rdata;
            end
            OWN_D: begin
              bus.d_ack <= 1'b1;
              if (!lat_we_q) bus.d_rdata <= bus.mem_rdata;
            end
            OWN_LD: begin
              bus.ld_ack <= 1'b1;
              if (!lat_we_q) bus.ld_rdata <= bus.mem_rdata;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  // Count data grants issued while fetch is waiting; any fetch grant or a
  // cycle without a fetch request starts the count over
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= '0;
    end else if (!bus.if_req) begin
      starve_q <= '0;
    end else if (state_q == S_IDLE) begin
      if (winner == OWN_IF) begin
        starve_q <= '0;
      end else if (winner == OWN_D && starve_q != CNT_MAX) begin
        starve_q <= starve_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected grants and completions are
// queued when stimulus is launched and compared as the DUT produces them.
module tb_mem_port_arbiter;

  localparam int unsigned STARVE_LIMIT = 3;
  localparam logic [1:0]  P_NONE = 2'b00;
  localparam logic [1:0]  P_IF   = 2'b01;
  localparam logic [1:0]  P_D    = 2'b10;
  localparam logic [1:0]  P_LD   = 2'b11;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Power-up RAM contents
  function automatic logic [15:0] seed(input logic [15:0] a);
    case (a)
      16'h0010: return 16'hC0DE;
      16'h0012: return 16'hF00D;
      16'h0020: return 16'h5A5A;
      16'h0030: return 16'h1111;
      default:  return a ^ 16'hA5A5;
    endcase
  endfunction

  // Single-port RAM with one-cycle read latency
  logic [15:0] ram [logic [15:0]];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] = bus.mem_wdata;
      else bus.mem_rdata <= ram.exists(bus.mem_addr) ? ram[bus.mem_addr] : seed(bus.mem_addr);
    end
  end

  typedef struct {
    logic [1:0]  port;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } gexp_t;

  typedef struct {
    logic [1:0]  port;
    logic [15:0] rdata;
  } aexp_t;

  gexp_t       exp_g[$];
  aexp_t       exp_a[$];
  logic [15:0] shadow [logic [15:0]];
  logic [15:0] exp_rd [4];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int if_left  = 0;
  int d_left   = 0;
  int ld_left  = 0;
  int grant_cnt = 0;
  int ack_cnt   = 0;
  int en_cnt    = 0;
  int ack_cyc   [4];
  int grant_cyc [4];
  logic [1:0] prev_grant = 2'b00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic expect_grant(input logic [1:0] p, input logic we, input logic [15:0] a,
                              input logic [15:0] wd);
    gexp_t g;
    g = '{p, we, a, wd};
    exp_g.push_back(g);
  endtask

  // Queue a full transaction; a write leaves the port's read data untouched
  task automatic expect_txn(input logic [1:0] p, input logic we, input logic [15:0] a,
                            input logic [15:0] wd);
    aexp_t e;
    logic [15:0] rd;
    expect_grant(p, we, a, wd);
    if (we) begin
      shadow[a] = wd;
      rd = exp_rd[p];
    end else begin
      rd = shadow.exists(a) ? shadow[a] : seed(a);
    end
    exp_rd[p] = rd;
    e = '{p, rd};
    exp_a.push_back(e);
  endtask

  function automatic logic [15:0] port_rdata(input logic [1:0] p);
    case (p)
      P_IF:    return bus.if_rdata;
      P_D:     return bus.d_rdata;
      default: return bus.ld_rdata;
    endcase
  endfunction

  task automatic monitor();
    logic [2:0] acks;
    logic [1:0] p;
    gexp_t g;
    aexp_t a;
    if (rst) begin
      prev_grant = P_NONE;
      return;
    end
    if (bus.mem_en) en_cnt++;
    acks = {bus.ld_ack, bus.d_ack, bus.if_ack};
    if (acks != 3'b000) begin
      check("ack_onehot", $countones(acks), 1);
      p = bus.if_ack ? P_IF : (bus.d_ack ? P_D : P_LD);
      ack_cnt++;
      ack_cyc[p] = cyc;
      if (exp_a.size() == 0) begin
        check("unexpected_ack", {29'b0, acks}, 0);
      end else begin
        a = exp_a.pop_front();
        check("ack_port", p, a.port);
        check("ack_rdata", port_rdata(p), a.rdata);
      end
    end
    if (bus.grant != P_NONE && prev_grant == P_NONE) begin
      grant_cnt++;
      grant_cyc[bus.grant] = cyc;
      check("access_mem_en", bus.mem_en, 1);
      check("access_busy", bus.busy, 1);
      if (exp_g.size() == 0) begin
        check("unexpected_grant", bus.grant, P_NONE);
      end else begin
        g = exp_g.pop_front();
        check("grant", bus.grant, g.port);
        check("mem_we", bus.mem_we, g.we);
        check("mem_addr", bus.mem_addr, g.addr);
        if (g.we) check("mem_wdata", bus.mem_wdata, g.wdata);
      end
    end
    prev_grant = bus.grant;
  endtask

  // Requesters hold their request until acked, then re-assert if more work remains
  task automatic step();
    @(negedge clk);
    cyc++;
    monitor();
    if (bus.if_ack && if_left > 0) if_left--;
    if (bus.d_ack && d_left > 0) d_left--;
    if (bus.ld_ack && ld_left > 0) ld_left--;
    bus.if_req = (if_left > 0);
    bus.d_req  = (d_left > 0);
    bus.ld_req = (ld_left > 0);
  endtask

  task automatic launch(input int nif, input int nd, input int nld);
    if_left = nif;
    d_left  = nd;
    ld_left = nld;
    bus.if_req = (if_left > 0);
    bus.d_req  = (d_left > 0);
    bus.ld_req = (ld_left > 0);
  endtask

  function automatic logic all_done();
    return (if_left == 0) && (d_left == 0) && (ld_left == 0) &&
           (exp_a.size() == 0) && (exp_g.size() == 0) && !bus.busy;
  endfunction

  task automatic run(input int max_cycles);
    int n;
    n = 0;
    while (!all_done() && n < max_cycles) begin
      step();
      n++;
    end
    check("run_done", all_done(), 1);
    repeat (2) step();
  endtask

  initial begin
    int c0;
    int en0;
    int ack0;
    int gr0;

    rst = 1'b1;
    bus.halted = 1'b0;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.ld_req = 1'b0; bus.ld_we = 1'b0; bus.ld_addr = '0; bus.ld_wdata = '0;
    for (int i = 0; i < 4; i++) exp_rd[i] = 16'h0000;

    // Reset state
    repeat (2) step();
    check("rst_grant", bus.grant, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_mem_en", bus.mem_en, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_acks", {bus.ld_ack, bus.d_ack, bus.if_ack}, 0);
    check("rst_rdata", {bus.if_rdata, bus.d_rdata} | bus.ld_rdata, 0);

    // Fetch only, requested as reset falls: grant on the first edge
    bus.if_addr = 16'h0010;
    expect_txn(P_IF, 1'b0, 16'h0010, 16'h0000);
    rst = 1'b0;
    c0 = cyc;
    en0 = en_cnt;
    launch(1, 0, 0);
    run(40);
    check("fetch_grant_lat", grant_cyc[P_IF] - c0, 1);
    check("fetch_ack_lat", ack_cyc[P_IF] - c0, 3);
    check("fetch_en_cycles", en_cnt - en0, 1);

    // Collision: data first, fetch granted in the d_ack cycle
    bus.d_we = 1'b0; bus.d_addr = 16'h0020;
    expect_txn(P_D, 1'b0, 16'h0020, 16'h0000);
    expect_txn(P_IF, 1'b0, 16'h0010, 16'h0000);
    launch(1, 1, 0);
    run(40);
    check("coll_if_grant_in_dack", grant_cyc[P_IF] - ack_cyc[P_D], 1);
    check("coll_if_ack_after_dack", ack_cyc[P_IF] - ack_cyc[P_D], 3);

    // Data write: acked 3 cycles later, d_rdata keeps the previous read value
    bus.d_we = 1'b1; bus.d_addr = 16'h0030; bus.d_wdata = 16'h1234;
    expect_txn(P_D, 1'b1, 16'h0030, 16'h1234);
    c0 = cyc;
    launch(0, 1, 0);
    run(40);
    check("write_ack_lat", ack_cyc[P_D] - c0, 3);

    // Loader blocked while running
    bus.ld_we = 1'b1; bus.ld_addr = 16'h0005; bus.ld_wdata = 16'hBEEF;
    gr0 = grant_cnt;
    launch(0, 0, 1);
    repeat (10) step();
    check("ld_blocked_grants", grant_cnt - gr0, 0);
    check("ld_blocked_grant", bus.grant, 0);

    // Halted: loader write beats pending data read, which then sees the new value
    bus.halted = 1'b1;
    bus.d_we = 1'b0; bus.d_addr = 16'h0005;
    expect_txn(P_LD, 1'b1, 16'h0005, 16'hBEEF);
    expect_txn(P_D, 1'b0, 16'h0005, 16'h0000);
    launch(0, 1, 1);
    run(40);

    // Starvation: loader keeps stealing the data-ack cycles, so data wins
    // three times in a row over a waiting fetch; the fourth goes to fetch
    bus.ld_we = 1'b0; bus.ld_addr = 16'h0010;
    bus.d_we = 1'b0; bus.d_addr = 16'h0020;
    bus.if_addr = 16'h0012;
    expect_txn(P_LD, 1'b0, 16'h0010, 16'h0000);
    expect_txn(P_D,  1'b0, 16'h0020, 16'h0000);
    expect_txn(P_LD, 1'b0, 16'h0010, 16'h0000);
    expect_txn(P_D,  1'b0, 16'h0020, 16'h0000);
    expect_txn(P_LD, 1'b0, 16'h0010, 16'h0000);
    expect_txn(P_D,  1'b0, 16'h0020, 16'h0000);
    expect_txn(P_LD, 1'b0, 16'h0010, 16'h0000);
    expect_txn(P_IF, 1'b0, 16'h0012, 16'h0000);
    expect_txn(P_D,  1'b0, 16'h0020, 16'h0000);
    launch(1, 4, 4);
    run(100);

    // Halted drops mid loader transaction: it still completes
    bus.ld_we = 1'b1; bus.ld_addr = 16'h0040; bus.ld_wdata = 16'h7777;
    expect_txn(P_LD, 1'b1, 16'h0040, 16'h7777);
    launch(0, 0, 1);
    step();
    bus.halted = 1'b0;
    run(40);

    // Reset during ACCESS: outputs drop at once, nothing is acked afterwards
    bus.d_we = 1'b0; bus.d_addr = 16'h0020;
    expect_grant(P_D, 1'b0, 16'h0020, 16'h0000);
    launch(0, 1, 0);
    step();
    check("pre_rst_mem_en", bus.mem_en, 1);
    rst = 1'b1;
    launch(0, 0, 0);
    #1;
    check("rst_mid_mem_en", bus.mem_en, 0);
    check("rst_mid_grant", bus.grant, 0);
    check("rst_mid_busy", bus.busy, 0);
    for (int i = 0; i < 4; i++) exp_rd[i] = 16'h0000;
    step();
    check("rst_mid_ld_rdata", bus.ld_rdata, 0);
    check("rst_mid_d_rdata", bus.d_rdata, 0);
    rst = 1'b0;
    ack0 = ack_cnt;
    gr0 = grant_cnt;
    repeat (6) step();
    check("no_ack_after_rst", ack_cnt - ack0, 0);
    check("no_grant_after_rst", grant_cnt - gr0, 0);

    // Normal service after reset
    bus.if_addr = 16'h0012;
    expect_txn(P_IF, 1'b0, 16'h0012, 16'h0000);
    launch(1, 0, 0);
    run(40);

    check("queues_drained", exp_a.size() + exp_g.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
